control_sequencer: RTL and testbench

- Microcoded control unit for the 8-bit bus computer.
- Steps through fetch and execute T-states and drives the OE/WE/load strobes consumed by the bus registers (A, B, IR, MAR, PC, RAM, OUT).
- Owns bus arbitration: at most one output enable is asserted in any state.
- Sits between the instruction register, the flags register and every bus-attached register.

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/microcode_rom.sv | 71 +++++++
 rtl/control_sequencer.sv | 115 +++++++++++
 tb/tb_control_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit bus computer control path.
//   - opcode constants (IR high nibble)
//   - T-state enumeration used by the sequencer counter
//   - control-word bit indices, shared by the sequencer, the register file
//     and any bench that inspects the strobes
package cpu_pkg;

    localparam int OPW_DEF = 4;
    localparam int TW_DEF  = 3;
    localparam int CW_W    = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Encodings 5..7 are illegal; the sequencer recovers to T0 from them.
    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_e;

    // Control-word bit positions.
    localparam int CW_PC_OE    = 0;
    localparam int CW_PC_INC   = 1;
    localparam int CW_PC_LOAD  = 2;
    localparam int CW_MAR_WE   = 3;
    localparam int CW_RAM_OE   = 4;
    localparam int CW_RAM_WE   = 5;
    localparam int CW_IR_WE    = 6;
    localparam int CW_IR_OE    = 7;
    localparam int CW_A_WE     = 8;
    localparam int CW_A_OE     = 9;
    localparam int CW_B_WE     = 10;
    localparam int CW_ALU_OE   = 11;
    localparam int CW_ALU_SUB  = 12;
    localparam int CW_FLAG_WE  = 13;
    localparam int CW_OUT_WE   = 14;
    localparam int CW_HLT      = 15;

    typedef logic [CW_W-1:0] cw_t;

    // One-hot control word with only bit idx set.
    function automatic cw_t cw_bit(input int idx);
        cw_t w;
        w = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// microcode_rom: purely combinational microcode table.
//   Inputs : tstate (current T-state), opcode (IR[7:4]), cf, zf (flags)
//   Outputs: cw (control word, bit layout from cpu_pkg),
//            last_step (this T-state is the final step of the instruction)
// Fetch steps T0/T1 ignore opcode and flags. Illegal T-states and steps an
// opcode does not use produce an all-zero word and flag last_step so the
// sequencer falls back to T0.
import cpu_pkg::*;

module microcode_rom #(
    parameter int OPW = OPW_DEF
) (
    input  tstate_e          tstate,
    input  logic [OPW-1:0]   opcode,
    input  logic             cf,
    input  logic             zf,
    output cw_t              cw,
    output logic             last_step
);

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        case (tstate)
            T0: cw = cw_bit(CW_PC_OE) | cw_bit(CW_MAR_WE);
            T1: cw = cw_bit(CW_RAM_OE) | cw_bit(CW_IR_WE) | cw_bit(CW_PC_INC);
            T2: begin
                last_step = 1'b1;
                case (opcode)
                    OPW'(OP_LDA), OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_STA): begin
                        cw        = cw_bit(CW_IR_OE) | cw_bit(CW_MAR_WE);
                        last_step = 1'b0;
                    end
                    OPW'(OP_LDI): cw = cw_bit(CW_IR_OE) | cw_bit(CW_A_WE);
                    OPW'(OP_JMP): cw = cw_bit(CW_IR_OE) | cw_bit(CW_PC_LOAD);
                    OPW'(OP_JC):  cw = cw_bit(CW_IR_OE) | (cf ? cw_bit(CW_PC_LOAD) : '0);
                    OPW'(OP_JZ):  cw = cw_bit(CW_IR_OE) | (zf ? cw_bit(CW_PC_LOAD) : '0);
                    OPW'(OP_OUT): cw = cw_bit(CW_A_OE) | cw_bit(CW_OUT_WE);
                    OPW'(OP_HLT): cw = cw_bit(CW_HLT);
                    default:      cw = '0;  // NOP and undefined opcodes
                endcase
            end
            T3: begin
                last_step = 1'b1;
                case (opcode)
                    OPW'(OP_LDA): cw = cw_bit(CW_RAM_OE) | cw_bit(CW_A_WE);
                    OPW'(OP_ADD), OPW'(OP_SUB): begin
                        cw        = cw_bit(CW_RAM_OE) | cw_bit(CW_B_WE);
                        last_step = 1'b0;
                    end
                    OPW'(OP_STA): cw = cw_bit(CW_A_OE) | cw_bit(CW_RAM_WE);
                    default:      cw = '0;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                case (opcode)
                    OPW'(OP_ADD): cw = cw_bit(CW_ALU_OE) | cw_bit(CW_A_WE) | cw_bit(CW_FLAG_WE);
                    OPW'(OP_SUB): cw = cw_bit(CW_ALU_OE) | cw_bit(CW_A_WE) | cw_bit(CW_FLAG_WE)
                                     | cw_bit(CW_ALU_SUB);
                    default:      cw = '0;
                endcase
            end
            default: begin
                cw        = '0;
                last_step = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state counter and halt logic for the 8-bit bus computer.
//   CLK, RESET_N (async active-low), EN (step enable)
//   OPCODE (IR[7:4]), CF, ZF (flags)
//   PC_OE/PC_INC/PC_LOAD, MAR_WE, RAM_OE/RAM_WE, IR_WE/IR_OE,
//   A_WE/A_OE/B_WE, ALU_OE/ALU_SUB/FLAG_WE, OUT_WE: bus register strobes
//   HLT: halted indicator; TSTATE: current T-state (debug)
// Strobes are decoded combinationally from the registered T-state and halted
// bit via microcode_rom. At most one *_OE is ever active, so this block is
// the bus arbiter.
import cpu_pkg::*;

module control_sequencer #(
    parameter int OPW = OPW_DEF,
    parameter int TW  = TW_DEF
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic           EN,
    input  logic [OPW-1:0] OPCODE,
    input  logic           CF,
    input  logic           ZF,
    output logic           PC_OE,
    output logic           PC_INC,
    output logic           PC_LOAD,
    output logic           MAR_WE,
    output logic           RAM_OE,
    output logic           RAM_WE,
    output logic           IR_WE,
    output logic           IR_OE,
    output logic           A_WE,
    output logic           A_OE,
    output logic           B_WE,
    output logic           ALU_OE,
    output logic           ALU_SUB,
    output logic           FLAG_WE,
    output logic           OUT_WE,
    output logic           HLT,
    output logic [TW-1:0]  TSTATE
);

    tstate_e state_q, state_d;
    logic    halted_q, halted_d;
    cw_t     rom_cw, cw_out;
    logic    last_step;

    microcode_rom #(.OPW(OPW)) u_rom (
        .tstate    (state_q),
        .opcode    (OPCODE),
        .cf        (CF),
        .zf        (ZF),
        .cw        (rom_cw),
        .last_step (last_step)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= T0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        cw_out   = '0;

        if (EN && !halted_q) begin
            case (state_q)
                T0: state_d = T1;
                T1: state_d = T2;
                T2: begin
                    if (!last_step) begin
                        state_d = T3;
                    end else if (OPCODE == OPW'(OP_HLT)) begin
                        // Park in T2 with the halted bit set; only reset leaves.
                        halted_d = 1'b1;
                    end else begin
                        state_d = T0;
                    end
                end
                T3:      state_d = last_step ? T0 : T4;
                T4:      state_d = T0;
                default: state_d = T0;
            endcase
        end

        // Gating with RESET_N kills every strobe the instant reset asserts,
        // rather than showing the T0 fetch word while reset is held.
        if (RESET_N) begin
            cw_out = halted_q ? cw_bit(CW_HLT) : rom_cw;
        end
    end

    assign PC_OE   = cw_out[CW_PC_OE];
    assign PC_INC  = cw_out[CW_PC_INC];
    assign PC_LOAD = cw_out[CW_PC_LOAD];
    assign MAR_WE  = cw_out[CW_MAR_WE];
    assign RAM_OE  = cw_out[CW_RAM_OE];
    assign RAM_WE  = cw_out[CW_RAM_WE];
    assign IR_WE   = cw_out[CW_IR_WE];
    assign IR_OE   = cw_out[CW_IR_OE];
    assign A_WE    = cw_out[CW_A_WE];
    assign A_OE    = cw_out[CW_A_OE];
    assign B_WE    = cw_out[CW_B_WE];
    assign ALU_OE  = cw_out[CW_ALU_OE];
    assign ALU_SUB = cw_out[CW_ALU_SUB];
    assign FLAG_WE = cw_out[CW_FLAG_WE];
    assign OUT_WE  = cw_out[CW_OUT_WE];
    assign HLT     = cw_out[CW_HLT];
    assign TSTATE  = TW'(state_q);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a driver issues one cycle of inputs at a time
// and pushes the hand-written expected {TSTATE, control word} for that cycle;
// a monitor on the falling edge pops and compares, and also checks that no
// two output enables are active together.
import cpu_pkg::*;

module tb_control_sequencer;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       EN = 1'b0;
    logic [3:0] OPCODE = 4'h0;
    logic       CF = 1'b0;
    logic       ZF = 1'b0;
    logic PC_OE, PC_INC, PC_LOAD, MAR_WE, RAM_OE, RAM_WE, IR_WE, IR_OE;
    logic A_WE, A_OE, B_WE, ALU_OE, ALU_SUB, FLAG_WE, OUT_WE, HLT;
    logic [2:0] TSTATE;

    control_sequencer dut (
        .CLK(CLK), .RESET_N(RESET_N), .EN(EN), .OPCODE(OPCODE), .CF(CF), .ZF(ZF),
        .PC_OE(PC_OE), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD), .MAR_WE(MAR_WE),
        .RAM_OE(RAM_OE), .RAM_WE(RAM_WE), .IR_WE(IR_WE), .IR_OE(IR_OE),
        .A_WE(A_WE), .A_OE(A_OE), .B_WE(B_WE), .ALU_OE(ALU_OE),
        .ALU_SUB(ALU_SUB), .FLAG_WE(FLAG_WE), .OUT_WE(OUT_WE), .HLT(HLT),
        .TSTATE(TSTATE)
    );

    // clock
    always #5 CLK = ~CLK;

    // Expected control words, written out from the instruction table.
    localparam logic [15:0] F0    = (16'd1 << CW_PC_OE)  | (16'd1 << CW_MAR_WE);
    localparam logic [15:0] F1    = (16'd1 << CW_RAM_OE) | (16'd1 << CW_IR_WE) | (16'd1 << CW_PC_INC);
    localparam logic [15:0] W_ADR = (16'd1 << CW_IR_OE)  | (16'd1 << CW_MAR_WE);
    localparam logic [15:0] W_LDA3 = (16'd1 << CW_RAM_OE) | (16'd1 << CW_A_WE);
    localparam logic [15:0] W_ADD3 = (16'd1 << CW_RAM_OE) | (16'd1 << CW_B_WE);
    localparam logic [15:0] W_ADD4 = (16'd1 << CW_ALU_OE) | (16'd1 << CW_A_WE) | (16'd1 << CW_FLAG_WE);
    localparam logic [15:0] W_SUB4 = W_ADD4 | (16'd1 << CW_ALU_SUB);
    localparam logic [15:0] W_STA3 = (16'd1 << CW_A_OE)   | (16'd1 << CW_RAM_WE);
    localparam logic [15:0] W_LDI2 = (16'd1 << CW_IR_OE)  | (16'd1 << CW_A_WE);
    localparam logic [15:0] W_JMP2 = (16'd1 << CW_IR_OE)  | (16'd1 << CW_PC_LOAD);
    localparam logic [15:0] W_JNO2 = (16'd1 << CW_IR_OE);
    localparam logic [15:0] W_OUT2 = (16'd1 << CW_A_OE)   | (16'd1 << CW_OUT_WE);
    localparam logic [15:0] W_HLT  = (16'd1 << CW_HLT);

    logic [18:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] dut_cw();
        logic [15:0] w;
        w = '0;
        w[CW_PC_OE] = PC_OE;   w[CW_PC_INC] = PC_INC;   w[CW_PC_LOAD] = PC_LOAD;
        w[CW_MAR_WE] = MAR_WE; w[CW_RAM_OE] = RAM_OE;   w[CW_RAM_WE] = RAM_WE;
        w[CW_IR_WE] = IR_WE;   w[CW_IR_OE] = IR_OE;     w[CW_A_WE] = A_WE;
        w[CW_A_OE] = A_OE;     w[CW_B_WE] = B_WE;       w[CW_ALU_OE] = ALU_OE;
        w[CW_ALU_SUB] = ALU_SUB; w[CW_FLAG_WE] = FLAG_WE; w[CW_OUT_WE] = OUT_WE;
        w[CW_HLT] = HLT;
        return w;
    endfunction

    // monitor / scoreboard
    always @(negedge CLK) begin
        logic [18:0] act, e;
        act = {TSTATE, dut_cw()};
        checks++;
        if ($countones({PC_OE, RAM_OE, IR_OE, A_OE, ALU_OE}) > 1) begin
            errors++;
            $display("FAIL oe_exclusive t=%0t ts=%0d cw=%h (at most one OE required)",
                     $time, TSTATE, act[15:0]);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL step t=%0t op=%h got ts=%0d cw=%h expected ts=%0d cw=%h",
                         $time, OPCODE, act[18:16], act[15:0], e[18:16], e[15:0]);
            end
        end
    end

    // Drive one cycle: inputs applied just after a rising edge, expectation
    // describes the outputs seen before the next rising edge.
    task automatic drive(input logic rst_n, input logic en, input logic [3:0] op,
                         input logic cf, input logic zf,
                         input logic [2:0] ts, input logic [15:0] cw);
        RESET_N = rst_n;
        EN      = en;
        OPCODE  = op;
        CF      = cf;
        ZF      = zf;
        exp_q.push_back({ts, cw});
        @(posedge CLK);
        #1;
    endtask

    // Unchecked cycle (used for the sweep, which relies on the OE monitor).
    task automatic free_cycle(input logic [3:0] op, input logic cf, input logic zf);
        RESET_N = 1'b1;
        EN      = 1'b1;
        OPCODE  = op;
        CF      = cf;
        ZF      = zf;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic cf, input logic zf,
                             input int nsteps, input logic [15:0] c2,
                             input logic [15:0] c3, input logic [15:0] c4);
        drive(1'b1, 1'b1, op, cf, zf, 3'd0, F0);
        drive(1'b1, 1'b1, op, cf, zf, 3'd1, F1);
        if (nsteps > 2) drive(1'b1, 1'b1, op, cf, zf, 3'd2, c2);
        if (nsteps > 3) drive(1'b1, 1'b1, op, cf, zf, 3'd3, c3);
        if (nsteps > 4) drive(1'b1, 1'b1, op, cf, zf, 3'd4, c4);
    endtask

    initial begin
        @(posedge CLK);
        #1;
        // reset state
        drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0000);

        // LDA then ADD, SUB, STA, LDI, JMP
        run_instr(OP_LDA, 1'b0, 1'b0, 4, W_ADR, W_LDA3, 16'h0);
        run_instr(OP_ADD, 1'b0, 1'b0, 5, W_ADR, W_ADD3, W_ADD4);
        run_instr(OP_SUB, 1'b1, 1'b1, 5, W_ADR, W_ADD3, W_SUB4);
        run_instr(OP_STA, 1'b0, 1'b0, 4, W_ADR, W_STA3, 16'h0);
        run_instr(OP_LDI, 1'b0, 1'b0, 3, W_LDI2, 16'h0, 16'h0);
        run_instr(OP_JMP, 1'b0, 1'b0, 3, W_JMP2, 16'h0, 16'h0);

        // conditional jumps: the other flag must not matter
        run_instr(OP_JC, 1'b0, 1'b1, 3, W_JNO2, 16'h0, 16'h0);
        run_instr(OP_JC, 1'b1, 1'b0, 3, W_JMP2, 16'h0, 16'h0);
        run_instr(OP_JZ, 1'b1, 1'b0, 3, W_JNO2, 16'h0, 16'h0);
        run_instr(OP_JZ, 1'b0, 1'b1, 3, W_JMP2, 16'h0, 16'h0);

        run_instr(OP_OUT, 1'b0, 1'b0, 3, W_OUT2, 16'h0, 16'h0);
        run_instr(OP_NOP, 1'b0, 1'b0, 3, 16'h0, 16'h0, 16'h0);
        for (int op = 9; op <= 13; op++) begin
            run_instr(4'(op), 1'b1, 1'b1, 3, 16'h0, 16'h0, 16'h0);
        end

        // EN low for 7 cycles in T1, then resume into T2
        drive(1'b1, 1'b1, OP_NOP, 1'b0, 1'b0, 3'd0, F0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, OP_NOP, 1'b0, 1'b0, 3'd1, F1);
        end
        drive(1'b1, 1'b1, OP_NOP, 1'b0, 1'b0, 3'd1, F1);
        drive(1'b1, 1'b1, OP_NOP, 1'b0, 1'b0, 3'd2, 16'h0);

        // reset mid-T3 of ADD, then a full LDA after release
        drive(1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 3'd0, F0);
        drive(1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 3'd1, F1);
        drive(1'b1, 1'b1, OP_ADD, 1'b0, 1'b0, 3'd2, W_ADR);
        drive(1'b0, 1'b1, OP_ADD, 1'b0, 1'b0, 3'd0, 16'h0);
        run_instr(OP_LDA, 1'b0, 1'b0, 4, W_ADR, W_LDA3, 16'h0);

        // HLT: held for 20 more clocks, then a reset pulse
        run_instr(OP_HLT, 1'b0, 1'b0, 3, W_HLT, 16'h0, 16'h0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, OP_HLT, i[0], i[1], 3'd2, W_HLT);
        end
        drive(1'b0, 1'b1, OP_HLT, 1'b0, 1'b0, 3'd0, 16'h0);
        run_instr(OP_LDI, 1'b0, 1'b0, 3, W_LDI2, 16'h0, 16'h0);

        // sweep every opcode and flag combination, OE exclusivity monitored
        for (int op = 0; op < 16; op++) begin
            for (int f = 0; f < 4; f++) begin
                for (int c = 0; c < 5; c++) begin
                    free_cycle(4'(op), f[0], f[1]);
                end
            end
        end
        drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 16'h0);
        run_instr(OP_ADD, 1'b0, 1'b0, 5, W_ADR, W_ADD3, W_ADD4);

        // drain, bounded
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge CLK);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
